// File: rtl/miner_core_compress_if.sv
// Bus between the SHA-256 compression core and its neighbours: start/state in,
// schedule-word read port, and result/status out. Vectors are MSB-at-bit-0.
interface miner_core_compress_if;
    logic         start;
    logic [0:255] h_in;
    logic [0:31]  w_word;
    logic [5:0]   w_idx;
    logic         busy;
    logic         done;
    logic [0:255] h_out;

    modport master (
        output start, h_in, w_word,
        input  w_idx, busy, done, h_out
    );

    modport slave (
        input  start, h_in, w_word,
        output w_idx, busy, done, h_out
    );
endinterface

// File: rtl/miner_core_compress.sv
// SHA-256 compression engine: latches a hash state, runs one round per clock
// reading W[t] from the schedule array, then folds the result into h_out.
module miner_core_compress #(
    parameter int NUM_ROUNDS = 64
) (
    input  logic                   clk,
    input  logic                   n_rst,
    miner_core_compress_if.slave   bus
);

    localparam int CW = $clog2(NUM_ROUNDS);

    localparam logic [31:0] K_ROM [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2
    } state_t;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    state_t        state_r;
    logic [CW-1:0] cnt_r;
    logic [31:0]   a_r, b_r, c_r, d_r, e_r, f_r, g_r, h_r;
    logic [0:255]  init_r;
    logic [0:255]  h_out_r;
    logic          done_r;
    logic          busy_r;

    logic [31:0]   s1_s, ch_s, t1_s, s0_s, maj_s, t2_s, k_s;
    logic [0:255]  wv_s;

    assign k_s   = K_ROM[cnt_r];
    assign s1_s  = rotr(e_r, 6) ^ rotr(e_r, 11) ^ rotr(e_r, 25);
    assign ch_s  = (e_r & f_r) ^ (~e_r & g_r);
    assign t1_s  = h_r + s1_s + ch_s + k_s + bus.w_word;
    assign s0_s  = rotr(a_r, 2) ^ rotr(a_r, 13) ^ rotr(a_r, 22);
    assign maj_s = (a_r & b_r) ^ (a_r & c_r) ^ (b_r & c_r);
    assign t2_s  = s0_s + maj_s;
    assign wv_s  = {a_r, b_r, c_r, d_r, e_r, f_r, g_r, h_r};

    // The counter is zero outside ROUND, so it doubles as the read index.
    assign bus.w_idx = cnt_r;
    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.h_out = h_out_r;

    // Control FSM, working variables and registered result/status.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r <= IDLE;
            cnt_r   <= {CW{1'b0}};
            {a_r, b_r, c_r, d_r, e_r, f_r, g_r, h_r} <= {256{1'b0}};
            init_r  <= {256{1'b0}};
            h_out_r <= {256{1'b0}};
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        {a_r, b_r, c_r, d_r, e_r, f_r, g_r, h_r} <= bus.h_in;
                        init_r  <= bus.h_in;
                        cnt_r   <= {CW{1'b0}};
                        busy_r  <= 1'b1;
                        state_r <= ROUND;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ROUND: begin
                    h_r <= g_r;
                    g_r <= f_r;
                    f_r <= e_r;
                    e_r <= d_r + t1_s;
                    d_r <= c_r;
                    c_r <= b_r;
                    b_r <= a_r;
                    a_r <= t1_s + t2_s;
                    if (cnt_r == CW'(NUM_ROUNDS - 1)) begin
                        cnt_r   <= {CW{1'b0}};
                        state_r <= FINAL;
                    end else begin
                        cnt_r   <= cnt_r + CW'(1);
                        state_r <= ROUND;
                    end
                end
                FINAL: begin
                    // Per-word modular add: carries never cross word boundaries.
                    for (int i = 0; i < 8; i++) begin
                        h_out_r[32*i +: 32] <= init_r[32*i +: 32] + wv_s[32*i +: 32];
                    end
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    cnt_r   <= {CW{1'b0}};
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_miner_core_compress.sv
// Scoreboard bench for miner_core_compress: stimulus pushes expected results,
// a negedge monitor checks w_idx, busy length, done timing/width and h_out.
module tb_miner_core_compress;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    miner_core_compress_if bus();
    miner_core_compress #(.NUM_ROUNDS(64)) dut (.clk(clk), .n_rst(n_rst), .bus(bus));

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [255:0] IV      = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] ABC_DIG = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] TWO_DIG = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    typedef struct {
        logic [255:0] h;
        int           dcyc;
    } exp_t;

    exp_t        exp_q [$];
    logic [31:0] w_mem [64];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;

    assign bus.w_word = w_mem[bus.w_idx];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // Message schedule: the W source the schedule array would provide.
    task automatic load_block(input logic [31:0] m [16]);
        logic [31:0] s0, s1;
        for (int t = 0; t < 16; t++) w_mem[t] = m[t];
        for (int t = 16; t < 64; t++) begin
            s0 = rotr(w_mem[t-15], 7) ^ rotr(w_mem[t-15], 18) ^ (w_mem[t-15] >> 3);
            s1 = rotr(w_mem[t-2], 17) ^ rotr(w_mem[t-2], 19) ^ (w_mem[t-2] >> 10);
            w_mem[t] = w_mem[t-16] + s0 + w_mem[t-7] + s1;
        end
    endtask

    function automatic logic [255:0] model(input logic [255:0] hin);
        logic [31:0]  v [8];
        logic [31:0]  hw [8];
        logic [31:0]  t1, t2;
        logic [255:0] r;
        for (int i = 0; i < 8; i++) begin
            hw[i] = hin[255-32*i -: 32];
            v[i]  = hw[i];
        end
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
                 + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[t] + w_mem[t];
            t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
                 + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int j = 7; j > 0; j--) v[j] = v[j-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[255-32*i -: 32] = hw[i] + v[i];
        return r;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic rand_block();
        logic [31:0] m [16];
        for (int i = 0; i < 16; i++) m[i] = $urandom;
        load_block(m);
    endtask

    // Monitor: per-cycle w_idx, busy length, done width/timing and result.
    initial begin
        int   k;
        logic prev_done;
        exp_t e;
        k = 0;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!n_rst) begin
                k = 0;
                prev_done = 1'b0;
            end else begin
                check("w_idx", 256'(bus.w_idx), bus.busy ? 256'((k < 64) ? k : 0) : 256'd0);
                if (bus.busy) k++;
                if (bus.done) begin
                    check("done_width", 256'(prev_done), 256'd0);
                    check("busy_len", 256'(k), 256'd65);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_done got done=1 want no pulse at cycle %0d", cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check("h_out", bus.h_out, e.h);
                        check("done_cycle", 256'(cyc), 256'(e.dcyc));
                    end
                end
                if (!bus.busy) k = 0;
                prev_done = bus.done;
            end
        end
    end

    // Waits for done at negedges, driving start from hold/pulse settings.
    task automatic wait_done(input int n0, input logic hold, input int pa, input int pb);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            bus.start = hold | (cyc == n0 + pa) | (cyc == n0 + pb);
            n++;
        end while (!bus.done && n < 200);
        if (!bus.done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout got no done want done within 200 cycles");
        end
    endtask

    task automatic run_block(input logic [255:0] h, input logic [255:0] exp,
                             input int pa, input int pb, output logic [255:0] got);
        int n0;
        @(negedge clk);
        bus.h_in  = h;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        n0 = cyc;
        exp_q.push_back('{h: exp, dcyc: n0 + 65});
        bus.h_in = rand256();
        wait_done(n0, 1'b0, pa, pb);
        bus.start = 1'b0;
        got = bus.h_out;
    endtask

    initial begin
        logic [31:0]  m [16];
        logic [255:0] got, got1, h, e;
        int           n0;

        bus.start = 1'b0;
        bus.h_in  = {256{1'b0}};
        for (int i = 0; i < 64; i++) w_mem[i] = 32'h0;
        #1;
        check("rst_busy", 256'(bus.busy), 256'd0);
        check("rst_done", 256'(bus.done), 256'd0);
        check("rst_h_out", bus.h_out, 256'd0);
        check("rst_w_idx", 256'(bus.w_idx), 256'd0);
        #12 n_rst = 1'b1;

        // Random blocks against the model.
        for (int b = 0; b < 4; b++) begin
            rand_block();
            h = rand256();
            run_block(h, model(h), -100, -100, got);
        end

        // Reset during round 30 of an "abc" block.
        m = '{32'h61626380, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
              32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h00000018};
        load_block(m);
        @(negedge clk);
        bus.h_in  = IV;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (30) @(posedge clk);
        #2 n_rst = 1'b0;
        #1;
        check("midrst_busy", 256'(bus.busy), 256'd0);
        check("midrst_done", 256'(bus.done), 256'd0);
        check("midrst_h_out", bus.h_out, 256'd0);
        check("midrst_w_idx", 256'(bus.w_idx), 256'd0);
        @(negedge clk);
        n_rst = 1'b1;

        run_block(IV, ABC_DIG, -100, -100, got);
        check("abc_model", model(IV), ABC_DIG);

        // Two-block message, chaining the hardware result.
        m = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
              32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
              32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
              32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
        load_block(m);
        run_block(IV, model(IV), -100, -100, got1);
        m = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
              32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h000001c0};
        load_block(m);
        run_block(got1, TWO_DIG, -100, -100, got);

        // Start re-pulsed at rounds 5 and 63 must not disturb anything.
        rand_block();
        h = rand256();
        run_block(h, model(h), 5, 63, got);
        repeat (3) @(negedge clk);

        // Start held across three back-to-back blocks.
        rand_block();
        h = rand256();
        e = model(h);
        @(negedge clk);
        bus.h_in  = h;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        n0 = cyc;
        exp_q.push_back('{h: e, dcyc: n0 + 65});
        wait_done(n0, 1'b1, -100, -100);
        for (int b = 1; b < 3; b++) begin
            rand_block();
            h = rand256();
            e = model(h);
            bus.h_in = h;
            n0 = cyc + 1;
            exp_q.push_back('{h: e, dcyc: n0 + 65});
            wait_done(n0, 1'b1, -100, -100);
        end
        bus.start = 1'b0;
        repeat (80) @(negedge clk);

        check("queue_empty", 256'(exp_q.size()), 256'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/miner_core_compress.md
Name: miner_core_compress

Overview:
- SHA-256 compression engine for the miner core; the consumer of the message schedule words produced by the scheduling array.
- Loads an initial hash state, then runs 64 rounds, one per clock. Each round reads schedule word W[t] through an index/data read port and pairs it with round constant K[t] from an internal ROM.
- At the end it adds the working variables back into the initial state and presents the 256-bit result with a one-cycle done pulse.
- Sits between the schedule array (W source) and the nonce/target comparator.

Parameters:
- NUM_ROUNDS, 64, rounds per block. Fixed for SHA-256; the parameter only sizes the counter and the last-round compare.

Ports:
- clk  input  1  system clock, rising edge.
- n_rst  input  1  asynchronous active-low reset.
- start  input  1  begin compression; sampled only in IDLE.
- h_in  input  256  initial hash state. Bits [0:31]=a/H0 through [224:255]=h/H7; bit 0 is the MSB.
- w_word  input  32  schedule word W[w_idx]; combinational return from the schedule array, bit 0 is the MSB.
- w_idx  output  6  index of the schedule word requested this cycle.
- busy  output  1  high in ROUND and FINAL.
- done  output  1  one-cycle pulse when h_out updates.
- h_out  output  256  final hash state, same packing as h_in; holds until the next done.

Behaviour:
- Reset (n_rst low, asynchronous): state=IDLE, round counter=0, a..h=0, saved initial state=0, h_out=0, done=0, busy=0, w_idx=0.
- States: IDLE, ROUND, FINAL.
- IDLE:
  - If start=1 at a rising edge: a..h <= h_in; initial-state register <= h_in; counter <= 0; go to ROUND.
  - Otherwise stay. done=0.
- ROUND (counter t):
  - w_idx = t, combinational from the counter.
  - Each edge performs one round, all arithmetic mod 2^32 with carries discarded:
    - S1 = rotr(e,6) ^ rotr(e,11) ^ rotr(e,25)
    - ch = (e & f) ^ (~e & g)
    - T1 = h + S1 + ch + K[t] + w_word
    - S0 = rotr(a,2) ^ rotr(a,13) ^ rotr(a,22)
    - maj = (a & b) ^ (a & c) ^ (b & c)
    - T2 = S0 + maj
    - Register update: h<=g, g<=f, f<=e, e<=d+T1, d<=c, c<=b, b<=a, a<=T1+T2.
  - t < 63: counter <= t+1, stay in ROUND.
  - t = 63: go to FINAL; counter wraps to 0.
- FINAL (one cycle):
  - h_out word i <= initial-state word i + working variable i, mod 2^32 per word, no carry between words.
  - done <= 1 (registered, so high for the cycle after this edge). Go to IDLE.
- K ROM: the 64 standard SHA-256 round constants. K[0]=428a2f98, K[63]=c67178f2.
- Latency: start sampled at edge E0; rounds execute at E1..E64; FINAL at E65. done and the new h_out are visible after E65, i.e. 65 cycles from start to result.
- busy is high from after E0 through the FINAL cycle.
- start while busy: ignored. No queuing, no restart.
- start held high continuously: a new block begins on the first IDLE edge after done. Back-to-back throughput is one block per 66 cycles.
- h_in changes after E0: no effect; the state was latched at E0.
- w_word must be stable and valid whenever busy is high in ROUND. The block performs no validity check.
- Reset asserted mid-operation: immediate return to the reset values. No done pulse; h_out cleared.
- Chained blocks: the caller feeds the previous h_out back as h_in. The block keeps no state between blocks other than h_out.

Test Plan:
- Reset mid-run: assert n_rst at round 30 → busy=0, done=0, h_out=0 immediately. A following start with the "abc" stimulus still yields ba7816bf….
- "abc" single block: h_in=IV (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19), bench serves W[0..63] from a model of the padded "abc" block → done exactly 65 cycles after start; h_out = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Two-block message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq": chain h_out of block 1 into h_in of block 2 → final h_out = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- w_idx sequence: monitor during any block → w_idx = 0,1,…,63 on consecutive cycles while in ROUND; 0 in IDLE.
- start re-pulsed at rounds 5 and 63 → no effect on the result or timing; exactly one done pulse, one cycle wide.
- start held high across three blocks → done pulses 66 cycles apart; each h_out matches the model.
